// File: rtl/xadc_pkg.sv
// Shared types and constants for the XADC DRP scan controller.
package xadc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_REQ    = 3'd2,
    ST_WAIT   = 3'd3,
    ST_PUSH   = 3'd4
  } state_e;

  localparam logic [6:0] DRP_ADDR_VAUX0 = 7'h10;
  localparam logic [6:0] DRP_ADDR_VPVN  = 7'h03;
  localparam logic [6:0] DRP_ADDR_TEMP  = 7'h00;
  localparam int         ADC_W          = 12;

  // The 12-bit conversion sits left-justified in the 16-bit DRP status word.
  function automatic logic [ADC_W-1:0] drp_result(input logic [15:0] word);
    return ADC_W'(word >> 4);
  endfunction

endpackage

// File: rtl/xadc_ch_select.sv
// Find-first-set over the scan mask, restricted to bits at or above start.
module xadc_ch_select #(
  parameter int NUM_CH = 4
) (
  input  logic [NUM_CH-1:0] mask,
  input  logic [3:0]        start,
  output logic              found,
  output logic [3:0]        idx
);

  logic [NUM_CH-1:0] hit_s;

  // Qualify mask bits by position, then scan downwards so the lowest hit wins.
  always_comb begin
    hit_s = {NUM_CH{1'b0}};
    idx   = 4'd0;
    for (int i = 0; i < NUM_CH; i++) begin
      hit_s[i] = mask[i] & (i >= int'(start));
    end
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx = hit_s[i] ? 4'(i) : idx;
    end
    found = |hit_s;
  end

endmodule

// File: rtl/xadc_scan_ctrl.sv
// DRP scan controller: each pacing tick reads every enabled VAUX channel once
// and hands the results to the consumer over a valid/ready handshake.
module xadc_scan_ctrl
  import xadc_pkg::*;
#(
  parameter int         NUM_CH    = 4,
  parameter logic [6:0] BASE_ADDR = DRP_ADDR_VAUX0,
  parameter int         TIMEOUT   = 255
) (
  input  logic              clkIn,
  input  logic              rstIn,
  input  logic              enIn,
  input  logic              tickIn,
  input  logic [NUM_CH-1:0] chMaskIn,
  input  logic              errClrIn,
  output logic              drpDenOut,
  output logic              drpDweOut,
  output logic [6:0]        drpAddrOut,
  input  logic              drpDrdyIn,
  input  logic [15:0]       drpDataIn,
  output logic [11:0]       dataOut,
  output logic [3:0]        chOut,
  output logic              validOut,
  input  logic              readyIn,
  output logic              busyOut,
  output logic              errOut,
  output logic              overrunOut
);

  state_e            state_q, state_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [3:0]        ptr_q, ptr_d;
  logic [3:0]        ch_q, ch_d;
  logic [3:0]        chout_q, chout_d;
  logic [7:0]        timer_q, timer_d;
  logic [ADC_W-1:0]  data_q, data_d;
  logic [6:0]        addr_q, addr_d;
  logic              den_q, den_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic              ovr_q, ovr_d;
  logic              err_set_s, ovr_set_s, last_ch_s;
  logic              sel_found_s;
  logic [3:0]        sel_idx_s;

  xadc_ch_select #(.NUM_CH(NUM_CH)) u_ch_select (
    .mask  (mask_q),
    .start (ptr_q),
    .found (sel_found_s),
    .idx   (sel_idx_s)
  );

  // Next-state logic; outputs are derived from the next state so they are registered.
  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    ptr_d     = ptr_q;
    ch_d      = ch_q;
    chout_d   = chout_q;
    timer_d   = timer_q;
    data_d    = data_q;
    err_set_s = 1'b0;
    ovr_set_s = tickIn & (state_q != ST_IDLE);
    last_ch_s = (ch_q == 4'(NUM_CH - 1));
    case (state_q)
      ST_IDLE: begin
        if (tickIn && enIn && (|chMaskIn)) begin
          mask_d  = chMaskIn;
          ptr_d   = 4'd0;
          state_d = ST_SELECT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SELECT: begin
        if (sel_found_s) begin
          ch_d    = sel_idx_s;
          state_d = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        timer_d = 8'd0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (drpDrdyIn) begin
          data_d  = drp_result(drpDataIn);
          chout_d = ch_q;
          state_d = ST_PUSH;
        end else if (timer_q == 8'(TIMEOUT - 1)) begin
          err_set_s = 1'b1;
          timer_d   = timer_q + 8'd1;
          // Abandon this channel; nothing remains above the last one.
          if (last_ch_s) begin
            state_d = ST_IDLE;
          end else begin
            ptr_d   = ch_q + 4'd1;
            state_d = ST_SELECT;
          end
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      ST_PUSH: begin
        if (readyIn && last_ch_s) begin
          state_d = ST_IDLE;
        end else if (readyIn) begin
          ptr_d   = ch_q + 4'd1;
          state_d = ST_SELECT;
        end else begin
          state_d = ST_PUSH;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    den_d   = (state_d == ST_REQ);
    addr_d  = (state_d == ST_REQ) ? (BASE_ADDR + {3'b000, ch_d}) : addr_q;
    valid_d = (state_d == ST_PUSH);
    busy_d  = (state_d != ST_IDLE);

    // A set event in the same cycle takes priority over the clear.
    if (err_set_s) begin
      err_d = 1'b1;
    end else if (errClrIn) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
    if (ovr_set_s) begin
      ovr_d = 1'b1;
    end else if (errClrIn) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clkIn or negedge rstIn) begin
    if (!rstIn) begin
      state_q <= ST_IDLE;
      mask_q  <= {NUM_CH{1'b0}};
      ptr_q   <= 4'd0;
      ch_q    <= 4'd0;
      chout_q <= 4'd0;
      timer_q <= 8'd0;
      data_q  <= {ADC_W{1'b0}};
      addr_q  <= 7'd0;
      den_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      ptr_q   <= ptr_d;
      ch_q    <= ch_d;
      chout_q <= chout_d;
      timer_q <= timer_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      den_q   <= den_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
    end
  end

  assign drpDenOut  = den_q;
  assign drpDweOut  = 1'b0;
  assign drpAddrOut = addr_q;
  assign dataOut    = data_q;
  assign chOut      = chout_q;
  assign validOut   = valid_q;
  assign busyOut    = busy_q;
  assign errOut     = err_q;
  assign overrunOut = ovr_q;

endmodule

// File: tb/tb_xadc_scan_ctrl.sv
// Scoreboard bench for xadc_scan_ctrl: a DRP responder, a per-scan reference
// model feeding expectation queues, and a monitor that checks each handshake.
module tb_xadc_scan_ctrl;

  localparam int         NUM_CH = 4;
  localparam logic [6:0] BASE   = 7'h10;
  localparam int         TMO    = 255;

  logic        clkIn = 1'b0;
  logic        rstIn = 1'b1;
  logic        enIn = 1'b0;
  logic        tickIn = 1'b0;
  logic [3:0]  chMaskIn = 4'd0;
  logic        errClrIn = 1'b0;
  logic        drpDrdyIn = 1'b0;
  logic [15:0] drpDataIn = 16'd0;
  logic        readyIn;
  logic        drpDenOut, drpDweOut, validOut, busyOut, errOut, overrunOut;
  logic [6:0]  drpAddrOut;
  logic [11:0] dataOut;
  logic [3:0]  chOut;

  int          total = 0;
  int          bad = 0;
  logic [15:0] exp_q[$];
  logic [6:0]  addr_q[$];
  logic [15:0] chan_data[NUM_CH];
  int          lat = 2;
  int          noans = -1;
  int          den_cnt = 0;
  bit          rand_ready = 1'b0;
  bit          rand_bit = 1'b1;
  bit          ready_man = 1'b1;

  assign readyIn = rand_ready ? rand_bit : ready_man;

  xadc_scan_ctrl #(.NUM_CH(NUM_CH), .BASE_ADDR(BASE), .TIMEOUT(TMO)) dut (
    .clkIn(clkIn), .rstIn(rstIn), .enIn(enIn), .tickIn(tickIn), .chMaskIn(chMaskIn),
    .errClrIn(errClrIn), .drpDenOut(drpDenOut), .drpDweOut(drpDweOut),
    .drpAddrOut(drpAddrOut), .drpDrdyIn(drpDrdyIn), .drpDataIn(drpDataIn),
    .dataOut(dataOut), .chOut(chOut), .validOut(validOut), .readyIn(readyIn),
    .busyOut(busyOut), .errOut(errOut), .overrunOut(overrunOut)
  );

  always #5 clkIn = ~clkIn;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s: event missing or unexpected (got otherwise, required the opposite)", nm);
  endtask

  // Reference model: a scan reads the enabled channels in ascending order.
  task automatic start_scan(input logic [3:0] m, input bit en, input bit fixed, input logic [15:0] fv);
    logic [15:0] d;
    for (int k = 0; k < NUM_CH; k++) chan_data[k] = fixed ? fv : 16'($urandom);
    chMaskIn = m;
    enIn = en;
    if (en && (m != 4'd0)) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (m[k]) begin
          addr_q.push_back(BASE + 7'(k));
          d = chan_data[k];
          if (k != noans) exp_q.push_back({4'(k), d[15:4]});
        end
      end
    end
    tickIn = 1'b1;
    @(negedge clkIn);
    tickIn = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    repeat (3) @(negedge clkIn);
    while (busyOut && n < 3000) begin
      @(negedge clkIn);
      n++;
    end
    if (busyOut) fail({nm, "_idle_timeout"});
    repeat (2) @(negedge clkIn);
    chk({nm, "_results_left"}, exp_q.size(), 0);
    chk({nm, "_addrs_left"}, addr_q.size(), 0);
  endtask

  task automatic set_ready(input bit rr, input bit man);
    @(posedge clkIn);
    #1;
    rand_ready = rr;
    ready_man = man;
    @(negedge clkIn);
  endtask

  initial forever begin
    @(posedge clkIn);
    #2;
    rand_bit = ($urandom_range(0, 2) != 0);
  end

  // DRP responder: answers each request after lat cycles, late for the silent channel.
  initial forever begin
    @(negedge clkIn);
    if (rstIn && drpDenOut) begin
      int k;
      k = int'(drpAddrOut - BASE);
      if (k == noans) repeat (TMO + 5) @(negedge clkIn);
      else repeat (lat) @(negedge clkIn);
      drpDataIn = chan_data[k];
      drpDrdyIn = 1'b1;
      @(negedge clkIn);
      drpDrdyIn = 1'b0;
      drpDataIn = 16'($urandom);
    end
  end

  // Monitor: pops expectations on handshakes and DRP requests.
  initial begin
    bit          hold_v;
    logic [15:0] hold_val;
    logic [15:0] e;
    hold_v = 1'b0;
    hold_val = 16'd0;
    forever begin
      @(negedge clkIn);
      if (!rstIn) begin
        hold_v = 1'b0;
      end else begin
        if (hold_v) begin
          chk("hold_valid", validOut, 1);
          chk("hold_result", {chOut, dataOut}, hold_val);
        end
        hold_v = validOut && !readyIn;
        hold_val = {chOut, dataOut};
        if (validOut && readyIn) begin
          if (exp_q.size() == 0) fail("unexpected_result");
          else begin
            e = exp_q.pop_front();
            chk("result", {chOut, dataOut}, e);
          end
        end
        if (drpDenOut) begin
          den_cnt++;
          chk("dwe", drpDweOut, 0);
          if (addr_q.size() == 0) fail("unexpected_den");
          else chk("drp_addr", drpAddrOut, addr_q.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int dc;
    logic [15:0] v;
    logic [3:0] m;
    bit en;

    #1 rstIn = 1'b0;
    repeat (3) @(negedge clkIn);
    chk("rst_den", drpDenOut, 0);
    chk("rst_addr", drpAddrOut, 0);
    chk("rst_data", dataOut, 0);
    chk("rst_ch", chOut, 0);
    chk("rst_valid", validOut, 0);
    chk("rst_busy", busyOut, 0);
    chk("rst_err", errOut, 0);
    chk("rst_ovr", overrunOut, 0);
    chk("rst_dwe", drpDweOut, 0);
    rstIn = 1'b1;
    @(negedge clkIn);
    set_ready(1'b0, 1'b1);

    // Mask 1011, fixed data, busy must drop right after the channel-3 handshake.
    lat = 2;
    start_scan(4'b1011, 1'b1, 1'b1, 16'hABC0);
    n = 0;
    while (!(validOut && chOut == 4'd3) && n < 200) begin
      @(negedge clkIn);
      n++;
    end
    if (n >= 200) fail("t1_ch3_result");
    else begin
      @(negedge clkIn);
      chk("t1_busy_after_last", busyOut, 0);
    end
    wait_idle("t1");

    // Latency: request in cycle N+2, answer in N+3, result in N+4.
    lat = 1;
    start_scan(4'b0001, 1'b1, 1'b0, 16'd0);
    chk("lat_den_n1", drpDenOut, 0);
    @(negedge clkIn);
    chk("lat_den_n2", drpDenOut, 1);
    chk("lat_addr_n2", drpAddrOut, 7'h10);
    @(negedge clkIn);
    chk("lat_den_n3", drpDenOut, 0);
    chk("lat_valid_n3", validOut, 0);
    @(negedge clkIn);
    chk("lat_valid_n4", validOut, 1);
    wait_idle("lat");

    // Consumer stalls for 10 cycles.
    lat = 2;
    set_ready(1'b0, 1'b0);
    start_scan(4'b0011, 1'b1, 1'b0, 16'd0);
    n = 0;
    while (!validOut && n < 50) begin
      @(negedge clkIn);
      n++;
    end
    v = {chOut, dataOut};
    dc = den_cnt;
    chk("stall_ch0", v[15:12], 0);
    repeat (10) begin
      @(negedge clkIn);
      chk("stall_valid", validOut, 1);
      chk("stall_result", {chOut, dataOut}, v);
    end
    chk("stall_no_den", den_cnt, dc);
    set_ready(1'b0, 1'b1);
    wait_idle("stall");

    // Channel 1 never answers in time.
    noans = 1;
    chk("tmo_err_before", errOut, 0);
    start_scan(4'b0011, 1'b1, 1'b0, 16'd0);
    n = 0;
    while (!(drpDenOut && drpAddrOut == 7'h11) && n < 100) begin
      @(negedge clkIn);
      n++;
    end
    if (n >= 100) fail("tmo_req_ch1");
    repeat (TMO) @(negedge clkIn);
    chk("tmo_err_early", errOut, 0);
    @(negedge clkIn);
    chk("tmo_err_set", errOut, 1);
    dc = 0;
    repeat (20) begin
      @(negedge clkIn);
      if (validOut) dc++;
    end
    chk("tmo_late_drdy_ignored", dc, 0);
    wait_idle("tmo");
    errClrIn = 1'b1;
    @(negedge clkIn);
    errClrIn = 1'b0;
    chk("tmo_err_cleared", errOut, 0);
    noans = -1;

    // Tick while busy and mask change mid-scan.
    dc = den_cnt;
    start_scan(4'b1111, 1'b1, 1'b0, 16'd0);
    repeat (4) @(negedge clkIn);
    chMaskIn = 4'b0001;
    tickIn = 1'b1;
    @(negedge clkIn);
    tickIn = 1'b0;
    chk("ovr_set", overrunOut, 1);
    wait_idle("ovr");
    chk("ovr_scan_count", den_cnt - dc, 4);
    errClrIn = 1'b1;
    @(negedge clkIn);
    errClrIn = 1'b0;
    chk("ovr_cleared", overrunOut, 0);

    // Asynchronous reset while waiting on the DRP.
    lat = 6;
    start_scan(4'b0011, 1'b1, 1'b0, 16'd0);
    n = 0;
    while (!drpDenOut && n < 50) begin
      @(negedge clkIn);
      n++;
    end
    repeat (2) @(negedge clkIn);
    chk("arst_busy_before", busyOut, 1);
    #2 rstIn = 1'b0;
    #1;
    chk("arst_busy", busyOut, 0);
    chk("arst_den", drpDenOut, 0);
    chk("arst_addr", drpAddrOut, 0);
    chk("arst_data", dataOut, 0);
    chk("arst_ch", chOut, 0);
    chk("arst_valid", validOut, 0);
    exp_q.delete();
    addr_q.delete();
    @(negedge clkIn);
    rstIn = 1'b1;
    dc = 0;
    repeat (12) begin
      @(negedge clkIn);
      if (validOut) dc++;
    end
    chk("arst_no_stale_valid", dc, 0);
    lat = 2;
    start_scan(4'b0011, 1'b1, 1'b0, 16'd0);
    wait_idle("arst_fresh");

    // Randomized scans with a random consumer.
    set_ready(1'b1, 1'b1);
    for (int it = 0; it < 25; it++) begin
      m = 4'($urandom_range(1, 15));
      if (it % 7 == 3) m = 4'd0;
      en = ($urandom_range(0, 3) != 0);
      lat = $urandom_range(1, 6);
      start_scan(m, en, 1'b0, 16'd0);
      wait_idle("rand");
    end
    set_ready(1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
